// File: rtl/adpll_pkg.sv
// Shared types and default gains for the ADPLL gear sequencer.
// The state encoding here is the same encoding driven on state_o.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } adpll_state_e;

    localparam logic [2:0] KP_ACQ_DEF = 3'b100;
    localparam logic [3:0] KI_ACQ_DEF = 4'b0100;
    localparam logic [2:0] KP_TRK_DEF = 3'b010;
    localparam logic [3:0] KI_TRK_DEF = 4'b0010;
    localparam logic [2:0] KP_LCK_DEF = 3'b001;
    localparam logic [3:0] KI_LCK_DEF = 4'b0001;

endpackage

// File: rtl/adpll_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector. The one-cycle
// strobe is high during the third clk_i cycle after the raw edge.
module adpll_edge_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic strobe_o
);

    logic sync0;
    logic sync1;
    logic sync2;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            strobe_o <= 1'b0;
        end else begin
            sync0    <= async_i;
            sync1    <= sync0;
            sync2    <= sync1;
            strobe_o <= sync1 & ~sync2;
        end
    end

endmodule

// File: rtl/adpll_gear_ctrl.sv
// Gain-scheduling and lock-detect sequencer: IDLE -> ACQUIRE -> TRACK -> LOCKED,
// with FAULT on acquisition timeout. Define ADPLL_UNLOCK_DETECT_EN to let LOCKED
// fall back to TRACK after UNLOCK_COUNT consecutive large errors.
module adpll_gear_ctrl
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = 8,
    parameter int KP_WIDTH = 3,
    parameter int KI_WIDTH = 4,
    parameter logic [KP_WIDTH-1:0] KP_ACQ = KP_ACQ_DEF,
    parameter logic [KI_WIDTH-1:0] KI_ACQ = KI_ACQ_DEF,
    parameter logic [KP_WIDTH-1:0] KP_TRK = KP_TRK_DEF,
    parameter logic [KI_WIDTH-1:0] KI_TRK = KI_TRK_DEF,
    parameter logic [KP_WIDTH-1:0] KP_LCK = KP_LCK_DEF,
    parameter logic [KI_WIDTH-1:0] KI_LCK = KI_LCK_DEF,
    parameter int ACQ_THRESH = 16,
    parameter int LOCK_THRESH = 2,
    parameter int GEAR_COUNT = 8,
    parameter int LOCK_COUNT = 32,
    parameter int TIMEOUT_SAMPLES = 1024,
`ifdef ADPLL_UNLOCK_DETECT_EN
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT = 4,
`endif
    parameter int CNT_WIDTH = 11
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   ref_clk_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    output logic                   enable_o,
    output logic [KP_WIDTH-1:0]    kp_o,
    output logic [KI_WIDTH-1:0]    ki_o,
    output logic                   locked_o,
    output logic                   fault_o,
    output logic [2:0]             state_o
);

    localparam logic [ERROR_WIDTH-1:0] ACQ_TH  = ERROR_WIDTH'(ACQ_THRESH);
    localparam logic [ERROR_WIDTH-1:0] LOCK_TH = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0]   GEAR_N  = CNT_WIDTH'(GEAR_COUNT);
    localparam logic [CNT_WIDTH-1:0]   LOCK_N  = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0]   TMO_N   = CNT_WIDTH'(TIMEOUT_SAMPLES);
    localparam logic [ERROR_WIDTH-1:0] MOST_NEG = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] MAX_POS  = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
`ifdef ADPLL_UNLOCK_DETECT_EN
    localparam logic [ERROR_WIDTH-1:0] UNL_TH = ERROR_WIDTH'(UNLOCK_THRESH);
    localparam logic [CNT_WIDTH-1:0]   UNL_N  = CNT_WIDTH'(UNLOCK_COUNT);
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    adpll_state_e state, state_n;
    logic [CNT_WIDTH-1:0] run_cnt, run_n;
    logic [CNT_WIDTH-1:0] tmo_cnt, tmo_n;
`ifdef ADPLL_UNLOCK_DETECT_EN
    logic [CNT_WIDTH-1:0] unl_cnt, unl_n;
`endif
    logic strobe;
    logic [ERROR_WIDTH-1:0] mag;

    adpll_edge_sync u_ref_sync (
        .clk_i    (fpga_clk_i),
        .reset_i  (reset_i),
        .async_i  (ref_clk_i),
        .strobe_o (strobe)
    );

    // Two's-complement magnitude; the most-negative code has no positive twin.
    always_comb begin
        mag = error_i;
        if (error_i == MOST_NEG)
            mag = MAX_POS;
        else if (error_i[ERROR_WIDTH-1])
            mag = ~error_i + ERROR_WIDTH'(1);
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= ST_IDLE;
            run_cnt <= '0;
            tmo_cnt <= '0;
`ifdef ADPLL_UNLOCK_DETECT_EN
            unl_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            run_cnt <= run_n;
            tmo_cnt <= tmo_n;
`ifdef ADPLL_UNLOCK_DETECT_EN
            unl_cnt <= unl_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        run_n   = run_cnt;
        tmo_n   = tmo_cnt;
`ifdef ADPLL_UNLOCK_DETECT_EN
        unl_n   = unl_cnt;
`endif
        if (!enable_i) begin
            // Dropping the request wins over anything a strobe would do.
            state_n = ST_IDLE;
            run_n   = '0;
            tmo_n   = '0;
`ifdef ADPLL_UNLOCK_DETECT_EN
            unl_n   = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_ACQUIRE;
                    run_n   = '0;
                    tmo_n   = '0;
                end
                ST_ACQUIRE: begin
                    if (strobe) begin
                        tmo_n = sat_inc(tmo_cnt);
                        run_n = (mag <= ACQ_TH) ? sat_inc(run_cnt) : '0;
                        if (run_n >= GEAR_N) begin
                            state_n = ST_TRACK;
                            run_n   = '0;
                            tmo_n   = '0;
                        end else if (tmo_n >= TMO_N) begin
                            state_n = ST_FAULT;
                        end
                    end
                end
                ST_TRACK: begin
                    if (strobe) begin
                        if (mag > ACQ_TH) begin
                            state_n = ST_ACQUIRE;
                            run_n   = '0;
                            tmo_n   = '0;
                        end else begin
                            run_n = (mag <= LOCK_TH) ? sat_inc(run_cnt) : '0;
                            if (run_n >= LOCK_N) begin
                                state_n = ST_LOCKED;
                                run_n   = '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
`ifdef ADPLL_UNLOCK_DETECT_EN
                    if (strobe) begin
                        unl_n = (mag > UNL_TH) ? sat_inc(unl_cnt) : '0;
                        if (unl_n >= UNL_N) begin
                            state_n = ST_TRACK;
                            run_n   = '0;
                            unl_n   = '0;
                        end
                    end
`endif
                end
                ST_FAULT: state_n = ST_FAULT;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        enable_o = 1'b0;
        kp_o     = KP_ACQ;
        ki_o     = KI_ACQ;
        locked_o = 1'b0;
        fault_o  = 1'b0;
        state_o  = state;
        case (state)
            ST_ACQUIRE: enable_o = 1'b1;
            ST_TRACK: begin
                enable_o = 1'b1;
                kp_o     = KP_TRK;
                ki_o     = KI_TRK;
            end
            ST_LOCKED: begin
                enable_o = 1'b1;
                kp_o     = KP_LCK;
                ki_o     = KI_LCK;
                locked_o = 1'b1;
            end
            ST_FAULT: fault_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adpll_gear_ctrl.sv
// Directed bench for adpll_gear_ctrl; build with +define+ADPLL_UNLOCK_DETECT_EN
// to also exercise the unlock path.
module tb_adpll_gear_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       ref_clk;
    logic [7:0] error_i;
    logic       enable_o;
    logic [2:0] kp_o;
    logic [3:0] ki_o;
    logic       locked_o;
    logic       fault_o;
    logic [2:0] state_o;

    int n_pass  = 0;
    int n_total = 0;

    adpll_gear_ctrl dut (
        .fpga_clk_i (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ref_clk_i  (ref_clk),
        .error_i    (error_i),
        .enable_o   (enable_o),
        .kp_o       (kp_o),
        .ki_o       (ki_o),
        .locked_o   (locked_o),
        .fault_o    (fault_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // One full reference period; returns at posedge+1 after the state update.
    task automatic send_strobe(input logic [7:0] err, input int half);
        error_i = err;
        ref_clk = 1'b1;
        repeat (half) @(posedge clk);
        #1;
        ref_clk = 1'b0;
        repeat (half) @(posedge clk);
        #1;
    endtask

    task automatic run_strobes(input int n, input logic [7:0] err, input int half);
        for (int i = 0; i < n; i++) send_strobe(err, half);
    endtask

    task automatic restart();
        enable_i = 1'b0;
        @(posedge clk); #1;
        enable_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; enable_i = 1'b0; ref_clk = 1'b0; error_i = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({state_o, enable_o, kp_o, ki_o, locked_o, fault_o} !== {3'd0, 1'b0, 3'd4, 4'd4, 1'b0, 1'b0})
            $display("FAIL reset_outputs state=%0d en=%b kp=%0d ki=%0d lk=%b ft=%b exp 0/0/4/4/0/0",
                     state_o, enable_o, kp_o, ki_o, locked_o, fault_o);
        else n_pass++;
        reset_i = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (state_o !== 3'd0) $display("FAIL idle_hold state=%0d exp=0", state_o);
        else n_pass++;
    endtask

    task automatic test_lock_sequence();
        enable_i = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({state_o, enable_o, kp_o, ki_o} !== {3'd1, 1'b1, 3'd4, 4'd4})
            $display("FAIL acq_entry state=%0d en=%b kp=%0d ki=%0d exp 1/1/4/4", state_o, enable_o, kp_o, ki_o);
        else n_pass++;
        run_strobes(7, 8'd0, 26);
        n_total++;
        if (state_o !== 3'd1) $display("FAIL acq_after7 state=%0d exp=1", state_o);
        else n_pass++;
        // 8th strobe: still ACQUIRE on the strobe cycle, TRACK one edge later.
        error_i = 8'd0;
        ref_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (state_o !== 3'd1) $display("FAIL strobe_cycle state=%0d exp=1", state_o);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({state_o, kp_o, ki_o} !== {3'd2, 3'd2, 4'd2})
            $display("FAIL track_entry state=%0d kp=%0d ki=%0d exp 2/2/2", state_o, kp_o, ki_o);
        else n_pass++;
        repeat (22) @(posedge clk);
        #1;
        ref_clk = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        run_strobes(31, 8'd0, 26);
        n_total++;
        if (state_o !== 3'd2) $display("FAIL track_after31 state=%0d exp=2", state_o);
        else n_pass++;
        send_strobe(8'd0, 26);
        n_total++;
        if ({state_o, kp_o, ki_o, locked_o, enable_o} !== {3'd3, 3'd1, 4'd1, 1'b1, 1'b1})
            $display("FAIL locked_entry state=%0d kp=%0d ki=%0d lk=%b en=%b exp 3/1/1/1/1",
                     state_o, kp_o, ki_o, locked_o, enable_o);
        else n_pass++;
`ifndef ADPLL_UNLOCK_DETECT_EN
        run_strobes(5, 8'd100, 4);
        n_total++;
        if (locked_o !== 1'b1 || state_o !== 3'd3)
            $display("FAIL locked_sticky state=%0d lk=%b exp 3/1", state_o, locked_o);
        else n_pass++;
`endif
    endtask

    task automatic test_track_fallback();
        enable_i = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({state_o, enable_o, kp_o, locked_o} !== {3'd0, 1'b0, 3'd4, 1'b0})
            $display("FAIL disable_idle state=%0d en=%b kp=%0d lk=%b exp 0/0/4/0", state_o, enable_o, kp_o, locked_o);
        else n_pass++;
        enable_i = 1'b1;
        @(posedge clk); #1;
        run_strobes(8, 8'd16, 4);
        n_total++;
        if (state_o !== 3'd2) $display("FAIL acq_thresh_incl state=%0d exp=2", state_o);
        else n_pass++;
        run_strobes(31, 8'd0, 4);
        send_strobe(8'd20, 4);
        n_total++;
        if ({state_o, kp_o, ki_o} !== {3'd1, 3'd4, 4'd4})
            $display("FAIL track_fallback state=%0d kp=%0d ki=%0d exp 1/4/4", state_o, kp_o, ki_o);
        else n_pass++;
        run_strobes(7, 8'd0, 4);
        n_total++;
        if (state_o !== 3'd1) $display("FAIL run_cleared state=%0d exp=1", state_o);
        else n_pass++;
        send_strobe(8'd0, 4);
        run_strobes(31, 8'd0, 4);
        send_strobe(8'd3, 4);
        run_strobes(31, 8'd0, 4);
        n_total++;
        if (state_o !== 3'd2) $display("FAIL lock_thresh_reset state=%0d exp=2", state_o);
        else n_pass++;
        send_strobe(8'd0, 4);
        n_total++;
        if (state_o !== 3'd3) $display("FAIL relock state=%0d exp=3", state_o);
        else n_pass++;
    endtask

    task automatic test_neg_saturation();
        restart();
        run_strobes(8, 8'hF0, 4);
        n_total++;
        if (state_o !== 3'd2) $display("FAIL neg16_track state=%0d exp=2", state_o);
        else n_pass++;
        send_strobe(8'h80, 4);
        n_total++;
        if (state_o !== 3'd1) $display("FAIL neg128_fallback state=%0d exp=1", state_o);
        else n_pass++;
        run_strobes(8, 8'd0, 4);
        run_strobes(32, 8'hFE, 4);
        n_total++;
        if (state_o !== 3'd3) $display("FAIL neg2_lock state=%0d exp=3", state_o);
        else n_pass++;
    endtask

    task automatic test_fault();
        restart();
        for (int i = 0; i < 1016; i++) send_strobe((i % 2 == 0) ? 8'd30 : 8'hE2, 4);
        run_strobes(7, 8'd0, 4);
        n_total++;
        if (state_o !== 3'd1) $display("FAIL tmo_1023 state=%0d exp=1", state_o);
        else n_pass++;
        send_strobe(8'd0, 4);
        n_total++;
        if (state_o !== 3'd2) $display("FAIL track_beats_fault state=%0d exp=2", state_o);
        else n_pass++;
        restart();
        for (int i = 0; i < 1023; i++) send_strobe((i % 2 == 0) ? 8'd30 : 8'hE2, 4);
        n_total++;
        if (state_o !== 3'd1 || enable_o !== 1'b1)
            $display("FAIL pre_fault state=%0d en=%b exp 1/1", state_o, enable_o);
        else n_pass++;
        send_strobe(8'd30, 4);
        n_total++;
        if ({state_o, fault_o, enable_o, kp_o, ki_o} !== {3'd4, 1'b1, 1'b0, 3'd4, 4'd4})
            $display("FAIL fault_entry state=%0d ft=%b en=%b kp=%0d ki=%0d exp 4/1/0/4/4",
                     state_o, fault_o, enable_o, kp_o, ki_o);
        else n_pass++;
        run_strobes(9, 8'd0, 4);
        n_total++;
        if (state_o !== 3'd4) $display("FAIL fault_sticky state=%0d exp=4", state_o);
        else n_pass++;
        enable_i = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (state_o !== 3'd0 || fault_o !== 1'b0)
            $display("FAIL fault_exit state=%0d ft=%b exp 0/0", state_o, fault_o);
        else n_pass++;
    endtask

    task automatic test_enable_override();
        restart();
        run_strobes(8, 8'd0, 4);
        run_strobes(31, 8'd0, 4);
        error_i = 8'd0;
        ref_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable_i = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (state_o !== 3'd0 || locked_o !== 1'b0 || enable_o !== 1'b0)
            $display("FAIL en_override state=%0d lk=%b en=%b exp 0/0/0", state_o, locked_o, enable_o);
        else n_pass++;
        ref_clk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_total++;
        if (locked_o !== 1'b0) $display("FAIL en_override_hold lk=%b exp=0", locked_o);
        else n_pass++;
    endtask

`ifdef ADPLL_UNLOCK_DETECT_EN
    task automatic test_unlock();
        restart();
        run_strobes(8, 8'd0, 4);
        run_strobes(32, 8'd0, 4);
        run_strobes(3, 8'd9, 4);
        send_strobe(8'd0, 4);
        run_strobes(3, 8'd9, 4);
        send_strobe(8'd8, 4);
        n_total++;
        if (state_o !== 3'd3 || locked_o !== 1'b1)
            $display("FAIL unlock_cleared state=%0d lk=%b exp 3/1", state_o, locked_o);
        else n_pass++;
        run_strobes(4, 8'd9, 4);
        n_total++;
        if ({state_o, locked_o, kp_o} !== {3'd2, 1'b0, 3'd2})
            $display("FAIL unlock_track state=%0d lk=%b kp=%0d exp 2/0/2", state_o, locked_o, kp_o);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        restart();
        run_strobes(8, 8'd0, 4);
        run_strobes(32, 8'd0, 4);
        #2;
        reset_i = 1'b0;
        #1;
        n_total++;
        if ({state_o, enable_o, kp_o, ki_o, locked_o} !== {3'd0, 1'b0, 3'd4, 4'd4, 1'b0})
            $display("FAIL async_reset state=%0d en=%b kp=%0d ki=%0d lk=%b exp 0/0/4/4/0",
                     state_o, enable_o, kp_o, ki_o, locked_o);
        else n_pass++;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (state_o !== 3'd1) $display("FAIL post_reset_acq state=%0d exp=1", state_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_track_fallback();
        test_neg_saturation();
        test_fault();
        test_enable_override();
`ifdef ADPLL_UNLOCK_DETECT_EN
        test_unlock();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adpll_gear_ctrl.md
Name: adpll_gear_ctrl

Overview:
- Gain-scheduling and lock-detect sequencer for the ADPLL loop.
- Samples the phase-detector error once per reference period and gates the phase accumulator enable.
- Steps the loop-filter kp/ki through acquire, track and locked gears, and reports lock or acquisition fault.
- Drives the kp_i/ki_i/enable_i inputs of the ADPLL top; all logic in the fpga_clk_i domain.

Parameters:
- ERROR_WIDTH, 8, signed phase-error width.
- KP_WIDTH, 3, kp word width.
- KI_WIDTH, 4, ki word width.
- KP_ACQ / KI_ACQ, 3'b100 / 4'b0100, acquire-gear gains.
- KP_TRK / KI_TRK, 3'b010 / 4'b0010, track-gear gains.
- KP_LCK / KI_LCK, 3'b001 / 4'b0001, locked-gear gains.
- ACQ_THRESH, 16, |error| bound to count toward TRACK; exceeding it in TRACK falls back.
- LOCK_THRESH, 2, |error| bound to count toward LOCKED.
- GEAR_COUNT, 8, consecutive in-bound samples for ACQUIRE->TRACK.
- LOCK_COUNT, 32, consecutive in-bound samples for TRACK->LOCKED.
- TIMEOUT_SAMPLES, 1024, samples allowed in ACQUIRE before FAULT.
- CNT_WIDTH, 11, width of the run and timeout counters; must hold TIMEOUT_SAMPLES.

Ports:
- fpga_clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  level request to run the loop.
- ref_clk_i  in  1  reference clock, asynchronous to fpga_clk_i.
- error_i  in  ERROR_WIDTH  signed phase-detector error.
- enable_o  out  1  phase-accumulator enable.
- kp_o  out  KP_WIDTH  loop-filter kp.
- ki_o  out  KI_WIDTH  loop-filter ki.
- locked_o  out  1  high in LOCKED.
- fault_o  out  1  high in FAULT.
- state_o  out  3  encoded state: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3, FAULT=4.

Behaviour:
- Reset (reset_i=0, async): state IDLE, counters 0, enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, locked_o=0, fault_o=0, state_o=0, synchroniser flops 0.
- Sample strobe: ref_clk_i passes a 2-flop synchroniser; a rising-edge detect gives a one-cycle strobe 3 fpga_clk_i cycles after the raw edge. error_i is captured on the strobe cycle.
- Magnitude: |error| = -error for negatives; the most-negative code saturates to 2^(ERROR_WIDTH-1)-1.
- Registered outputs: state, kp_o, ki_o, enable_o, locked_o, fault_o and state_o all update on the clock edge that ends the strobe cycle (1-cycle latency from strobe).
- Priority: enable_i=0 in any state forces IDLE on the next edge, clears counters, drops enable_o. This overrides any same-cycle strobe transition.
- IDLE: enable_o=0, acquire gains. enable_i=1 -> ACQUIRE; counters cleared; enable_o=1 from this edge, no strobe needed.
- ACQUIRE (acquire gains, enable_o=1), on each strobe:
  - timeout counter +1.
  - |err|<=ACQ_THRESH: run counter +1, else run counter =0.
  - Run counter reaching GEAR_COUNT -> TRACK, run counter cleared.
  - Timeout counter reaching TIMEOUT_SAMPLES (and run not complete) -> FAULT.
  - If both occur on the same strobe, TRACK wins.
- TRACK (track gains), on each strobe:
  - |err|>ACQ_THRESH -> ACQUIRE, both counters cleared.
  - Else |err|<=LOCK_THRESH: run +1, otherwise run =0.
  - Run reaching LOCK_COUNT -> LOCKED.
- LOCKED: locked gains, locked_o=1. Sticky unless ADPLL_UNLOCK_DETECT_EN is defined.
- FAULT: enable_o=0, acquire gains, fault_o=1. Exits only through enable_i=0 -> IDLE.
- Counters saturate and never wrap. No transitions occur between strobes.
- Reset asserted mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: ADPLL_UNLOCK_DETECT_EN.
- Defined: adds parameters UNLOCK_THRESH=8 and UNLOCK_COUNT=4. In LOCKED, each strobe with |err|>UNLOCK_THRESH increments an unlock counter; an in-bound strobe clears it. Reaching UNLOCK_COUNT -> TRACK, locked_o drops on that edge, run counter cleared.
- Undefined: LOCKED is left only via enable_i=0 or reset.

Decomposition:
- Shared package adpll_pkg holds the state enum typedef (3-bit, encoding as state_o) and the default gain localparams.
- One sub-module, adpll_edge_sync: 2-flop synchroniser plus rising-edge strobe, reusable for other_clk_i.

Test Plan:
- Reset then enable_i=1, error constant 0, ref period 52 cycles -> ACQUIRE at 1 cycle; TRACK after 8 strobes; LOCKED after 32 more; kp_o 4->2->1, ki_o 4->2->1.
- In TRACK, one strobe with error=+20 -> ACQUIRE next cycle, counters cleared, gains back to KP_ACQ/KI_ACQ.
- Error alternating +30/-30 in ACQUIRE -> FAULT at strobe 1024, fault_o=1, enable_o=0; enable_i low -> IDLE, fault_o=0.
- error=-128 in TRACK -> treated as 127, falls back to ACQUIRE; error=-2 counts toward lock.
- enable_i deasserted on a strobe cycle that would enter LOCKED -> IDLE, locked_o stays 0.
- With ADPLL_UNLOCK_DETECT_EN, 4 consecutive error=+9 strobes in LOCKED -> TRACK, locked_o=0; 3 then one error=0 -> stays LOCKED.
